// File: rtl/bcd_display_scanner_if.sv
// Upstream-facing bundle for bcd_display_scanner: BCD load handshake plus the
// multiplexed two-digit 7-segment drive.
interface bcd_display_scanner_if;
  logic [7:0] BCD;
  logic       load;
  logic       load_ack;
  logic [6:0] seg;
  logic [1:0] an;
  logic       err;

  // master: upstream converter / display harness; slave: the scanner itself
  modport master (
    output BCD,
    output load,
    input  load_ack,
    input  seg,
    input  an,
    input  err
  );

  modport slave (
    input  BCD,
    input  load,
    output load_ack,
    output seg,
    output an,
    output err
  );
endinterface

// File: rtl/bcd_display_scanner.sv
// Two-digit BCD 7-segment scanner with frame-synchronous (tear-free) updates.
// Optional LEADING_ZERO_BLANK_EN blanks the tens digit when it is zero.
module bcd_display_scanner #(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input logic                  clk,
  input logic                  rst,
  bcd_display_scanner_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHOW_LO = 2'd1,
    SHOW_HI = 2'd2
  } state_t;

  localparam logic [15:0] DIV_LAST = 16'(REFRESH_DIV - 1);

  state_t      state, state_nxt;
  logic [15:0] div, div_nxt;
  logic [7:0]  disp, disp_nxt;
  logic [7:0]  shadow, shadow_nxt;
  logic        pend, pend_nxt;
  logic        tick;

  logic [6:0]  seg_q, seg_nxt;
  logic [1:0]  an_q, an_nxt;
  logic        err_q, err_nxt;
  logic        ack_q;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b1111110;
      4'd1:    decode = 7'b0110000;
      4'd2:    decode = 7'b1101101;
      4'd3:    decode = 7'b1111001;
      4'd4:    decode = 7'b0110011;
      4'd5:    decode = 7'b1011011;
      4'd6:    decode = 7'b1011111;
      4'd7:    decode = 7'b1110000;
      4'd8:    decode = 7'b1111111;
      4'd9:    decode = 7'b1111011;
      default: decode = 7'b1001111;  // "E" for non-BCD nibbles
    endcase
  endfunction

  assign tick = (state != IDLE) && (div == DIV_LAST);

  always_comb begin
    // NOTE: every variable gets a default up front so no path can infer a latch.
    state_nxt  = state;
    div_nxt    = div;
    disp_nxt   = disp;
    shadow_nxt = shadow;
    pend_nxt   = pend;

    case (state)
      IDLE: begin
        div_nxt = '0;
        if (bus.load) begin
          disp_nxt  = bus.BCD;
          state_nxt = SHOW_LO;
        end
      end
      SHOW_LO: begin
        div_nxt = tick ? '0 : div + 16'd1;
        if (tick) state_nxt = SHOW_HI;
      end
      SHOW_HI: begin
        div_nxt = tick ? '0 : div + 16'd1;
        if (tick) state_nxt = SHOW_LO;
      end
      default: begin
        state_nxt = IDLE;
        div_nxt   = '0;
      end
    endcase

    // Loads while scanning wait in the shadow until the frame boundary; a load
    // landing on the boundary itself bypasses the shadow entirely.
    if (bus.load && state != IDLE) begin
      if (state == SHOW_HI && tick) begin
        disp_nxt = bus.BCD;
        pend_nxt = 1'b0;
      end else begin
        shadow_nxt = bus.BCD;
        pend_nxt   = 1'b1;
      end
    end else if (state == SHOW_HI && tick && pend) begin
      disp_nxt = shadow;
      pend_nxt = 1'b0;
    end
  end

  // Output drive is computed from next-state values so the registered
  // outputs line up with the state they belong to.
  always_comb begin
    an_nxt  = 2'b11;
    seg_nxt = '0;
    case (state_nxt)
      SHOW_LO: begin
        an_nxt  = 2'b10;
        seg_nxt = decode(disp_nxt[3:0]);
      end
      SHOW_HI: begin
        an_nxt  = 2'b01;
`ifdef LEADING_ZERO_BLANK_EN
        seg_nxt = (disp_nxt[7:4] == 4'd0) ? 7'b0000000 : decode(disp_nxt[7:4]);
`else
        seg_nxt = decode(disp_nxt[7:4]);
`endif
      end
      default: begin
        an_nxt  = 2'b11;
        seg_nxt = '0;
      end
    endcase
    err_nxt = (disp_nxt[7:4] > 4'd9) || (disp_nxt[3:0] > 4'd9);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    // NOTE: the reset is synchronous and covers every register here; the
    // two 8-bit holding registers are plain flops, not memory, so clearing
    // them is cheap and keeps the post-reset state fully defined.
    if (rst) begin
      state  <= IDLE;
      div    <= '0;
      disp   <= 8'h00;
      shadow <= 8'h00;
      pend   <= 1'b0;
      seg_q  <= '0;
      an_q   <= 2'b11;
      err_q  <= 1'b0;
      ack_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      div    <= div_nxt;
      disp   <= disp_nxt;
      shadow <= shadow_nxt;
      pend   <= pend_nxt;
      seg_q  <= seg_nxt;
      an_q   <= an_nxt;
      err_q  <= err_nxt;
      ack_q  <= bus.load;
    end
  end

  assign bus.seg      = seg_q;
  assign bus.an       = an_q;
  assign bus.err      = err_q;
  assign bus.load_ack = ack_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed bench for bcd_display_scanner at REFRESH_DIV=4; expected segment
// patterns are hand-decoded constants.
module tb_bcd_display_scanner;

  localparam logic [6:0] S0 = 7'b1111110;
  localparam logic [6:0] S3 = 7'b1111001;
  localparam logic [6:0] S4 = 7'b0110011;
  localparam logic [6:0] S5 = 7'b1011011;
  localparam logic [6:0] S7 = 7'b1110000;
  localparam logic [6:0] S9 = 7'b1111011;
  localparam logic [6:0] SE = 7'b1001111;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] TENS_ZERO = 7'b0000000;
`else
  localparam logic [6:0] TENS_ZERO = S0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  bcd_display_scanner_if bus ();

  bcd_display_scanner #(.REFRESH_DIV(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, act, exp);
    end
  endtask

  // Advance one clock; observations land 1 ns after the rising edge.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_out(input string tag, input logic [1:0] an, input logic [6:0] seg);
    check({tag, ".an"}, {6'd0, bus.an}, {6'd0, an});
    check({tag, ".seg"}, {1'b0, bus.seg}, {1'b0, seg});
  endtask

  // Four consecutive cycles of one digit slot; leaves us on the next slot's first cycle.
  task automatic check_slot(input string tag, input logic [1:0] an, input logic [6:0] seg);
    for (int i = 0; i < 4; i++) begin
      check_out(tag, an, seg);
      step();
    end
  endtask

  task automatic pulse_load(input logic [7:0] v);
    bus.BCD  = v;
    bus.load = 1'b1;
    step();
    bus.load = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    bus.BCD  = 8'h00;
    bus.load = 1'b0;
    step(2);
    check_out("reset", 2'b11, 7'b0);
    check("reset.err", {7'd0, bus.err}, 8'd0);
    check("reset.ack", {7'd0, bus.load_ack}, 8'd0);

    // Load during reset is discarded and never acknowledged.
    bus.BCD  = 8'h47;
    bus.load = 1'b1;
    step();
    check("rst_load.ack", {7'd0, bus.load_ack}, 8'd0);
    rst      = 1'b0;
    bus.load = 1'b0;
    step();
    check("rst_load.ack2", {7'd0, bus.load_ack}, 8'd0);
    check_out("rst_load.idle", 2'b11, 7'b0);
    step(3);
    check_out("idle_hold", 2'b11, 7'b0);

    // Basic scan of 47.
    pulse_load(8'h47);
    check("ack47", {7'd0, bus.load_ack}, 8'd1);
    check_slot("f1.lo47", 2'b10, S7);
    check("ack47.clr", {7'd0, bus.load_ack}, 8'd0);
    check_slot("f1.hi47", 2'b01, S4);
    check_slot("f2.lo47", 2'b10, S7);
    check_slot("f2.hi47", 2'b01, S4);

    // Newest-wins shadow: 12 in SHOW_LO, 35 in SHOW_HI; 12 never displayed.
    pulse_load(8'h12);
    check("ack12", {7'd0, bus.load_ack}, 8'd1);
    check_out("lo_keep47", 2'b10, S7);
    step(3);
    check_out("hi_keep47", 2'b01, S4);
    pulse_load(8'h35);
    check("ack35", {7'd0, bus.load_ack}, 8'd1);
    check_out("hi_keep47b", 2'b01, S4);
    step(3);
    check_slot("f.lo35", 2'b10, S5);
    check_slot("f.hi35", 2'b01, S3);
    check_slot("f.lo35b", 2'b10, S5);
    step(4);

    // Invalid nibble: 3C shows E on units and raises err until a valid commit.
    pulse_load(8'h3C);
    check("pre3C.err", {7'd0, bus.err}, 8'd0);
    step(7);
    check("3C.err", {7'd0, bus.err}, 8'd1);
    check_slot("f.lo3C", 2'b10, SE);
    check_slot("f.hi3C", 2'b01, S3);
    pulse_load(8'h05);
    check("05.err_hold", {7'd0, bus.err}, 8'd1);
    step(7);
    check("05.err_clr", {7'd0, bus.err}, 8'd0);
    check_out("lo05", 2'b10, S5);
    step(4);
    check_out("hi05", 2'b01, TENS_ZERO);

    // Shadow 07, then 99 lands on the frame-boundary tick: direct commit, pending cleared.
    pulse_load(8'h07);
    step(2);
    bus.BCD  = 8'h99;
    bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    check("ack99", {7'd0, bus.load_ack}, 8'd1);
    check_out("lo99", 2'b10, S9);
    step(4);
    check_out("hi99", 2'b01, S9);
    step(4);
    check_out("lo99_nopend", 2'b10, S9);
    step(4);
    check_out("hi99_nopend", 2'b01, S9);
    step(4);

    // 07 through the normal path: units 7, tens zero.
    pulse_load(8'h07);
    step(7);
    check_out("lo07", 2'b10, S7);
    step(4);
    check_out("hi07", 2'b01, TENS_ZERO);

    // Reset mid-SHOW_HI with a load pending: blank IDLE next cycle, no ack.
    step();
    bus.BCD  = 8'h42;
    bus.load = 1'b1;
    rst      = 1'b1;
    step();
    check_out("midrst", 2'b11, 7'b0);
    check("midrst.ack", {7'd0, bus.load_ack}, 8'd0);
    check("midrst.err", {7'd0, bus.err}, 8'd0);
    rst      = 1'b0;
    bus.load = 1'b0;
    step(6);
    check_out("postrst_idle", 2'b11, 7'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
